// File: rtl/branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl
//
// Sequences misprediction recovery for results coming out of the branch unit.
// A mispredicted branch whose epoch matches the current global epoch starts a
// recovery sequence:
//   1. The global epoch is bumped, so results from the wrong path become stale.
//   2. A one-cycle flush is broadcast, carrying the branch's ROB index.
//   3. The controller waits for the ROB/RAT walk to report completion.
//   4. The frontend is steered to the correct PC through a valid/ready handshake.
// Fetch is stalled for the whole sequence. An older branch, tagged with the same
// (pre-bump) epoch, that resolves mid-sequence preempts the one in flight. It
// restarts the flush with its own index and PC and leaves the epoch unchanged.
//
// Ports
//   clk                  clock
//   rst_n                asynchronous active-low reset
//   br_valid_i           branch result valid (one-cycle pulse)
//   br_mispredict_i      result needs a redirect
//   br_epoch_i           epoch tag carried by the branch
//   br_rob_idx_i         ROB index of the branch
//   br_redirect_pc_i     correct next PC
//   rob_head_i           oldest ROB entry, reference point for age compares
//   recover_done_i       ROB/RAT recovery complete (level)
//   flush_valid_o        one-cycle flush broadcast
//   flush_rob_idx_o      ROB index of the mispredicted branch
//   cur_epoch_o          current global epoch
//   fe_stall_o           fetch stall, high whenever a sequence is in flight
//   fe_redirect_valid_o  redirect request to the frontend
//   fe_redirect_ready_i  frontend accepts the redirect
//   fe_redirect_pc_o     redirect target
//   mispredict_cnt_o     accepted-mispredict count, saturating
//
// Every output comes from a flop or from a decode of the state register, so no
// input reaches an output combinationally.
// ---------------------------------------------------------------------------
module branch_redirect_ctrl #(
  parameter int ROB_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid_i,
  input  logic             br_mispredict_i,
  input  logic [1:0]       br_epoch_i,
  input  logic [ROB_W-1:0] br_rob_idx_i,
  input  logic [31:0]      br_redirect_pc_i,
  input  logic [ROB_W-1:0] rob_head_i,
  input  logic             recover_done_i,
  output logic             flush_valid_o,
  output logic [ROB_W-1:0] flush_rob_idx_o,
  output logic [1:0]       cur_epoch_o,
  output logic             fe_stall_o,
  output logic             fe_redirect_valid_o,
  input  logic             fe_redirect_ready_i,
  output logic [31:0]      fe_redirect_pc_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_RECOVER  = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       cur_epoch_q, cur_epoch_d;
  logic [1:0]       pend_epoch_q, pend_epoch_d;
  logic [ROB_W-1:0] pend_rob_idx_q, pend_rob_idx_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_s;

  // Age compare on a circular ROB. Both indexes are rebased to the head so
  // that wrap-around does not matter. Equal indexes are never older.
  function automatic logic is_older(input logic [ROB_W-1:0] idx_a,
                                    input logic [ROB_W-1:0] idx_b,
                                    input logic [ROB_W-1:0] head);
    logic [ROB_W-1:0] dist_a;
    logic [ROB_W-1:0] dist_b;
    dist_a = idx_a - head;
    dist_b = idx_b - head;
    return (dist_a < dist_b);
  endfunction

  // Saturating increment for the mispredict counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] res;
    if (val == {CNT_W{1'b1}}) begin
      res = val;
    end else begin
      res = val + CNT_W'(1'b1);
    end
    return res;
  endfunction

  // Accept qualification: in IDLE, match the live epoch. Mid-sequence, only a
  // strictly older branch from the same pre-bump epoch may take over.
  always_comb begin
    accept_s = 1'b0;
    if (br_valid_i && br_mispredict_i) begin
      if (state_q == ST_IDLE) begin
        accept_s = (br_epoch_i == cur_epoch_q);
      end else begin
        accept_s = (br_epoch_i == pend_epoch_q) &&
                   is_older(br_rob_idx_i, pend_rob_idx_q, rob_head_i);
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  // Next-state logic. An accept wins over recover_done and the frontend
  // handshake in every busy state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (accept_s) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (accept_s) begin
          state_d = ST_FLUSH;
        end else if (recover_done_i) begin
          state_d = ST_REDIRECT;
        end else begin
          state_d = ST_RECOVER;
        end
      end
      ST_REDIRECT: begin
        if (accept_s) begin
          state_d = ST_FLUSH;
        end else if (fe_redirect_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REDIRECT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pending-branch and epoch bookkeeping. The epoch advances only when a
  // sequence starts from IDLE. A preempting branch already carries the
  // pre-bump epoch, so both epoch registers are left alone.
  always_comb begin
    cur_epoch_d    = cur_epoch_q;
    pend_epoch_d   = pend_epoch_q;
    pend_rob_idx_d = pend_rob_idx_q;
    pend_pc_d      = pend_pc_q;
    cnt_d          = cnt_q;
    if (accept_s) begin
      pend_rob_idx_d = br_rob_idx_i;
      pend_pc_d      = br_redirect_pc_i;
      cnt_d          = sat_inc(cnt_q);
      if (state_q == ST_IDLE) begin
        pend_epoch_d = br_epoch_i;
        cur_epoch_d  = cur_epoch_q + 2'd1;
      end else begin
        pend_epoch_d = pend_epoch_q;
        cur_epoch_d  = cur_epoch_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cur_epoch_q    <= 2'd0;
      pend_epoch_q   <= 2'd0;
      pend_rob_idx_q <= {ROB_W{1'b0}};
      pend_pc_q      <= 32'd0;
      cnt_q          <= {CNT_W{1'b0}};
    end else begin
      state_q        <= state_d;
      cur_epoch_q    <= cur_epoch_d;
      pend_epoch_q   <= pend_epoch_d;
      pend_rob_idx_q <= pend_rob_idx_d;
      pend_pc_q      <= pend_pc_d;
      cnt_q          <= cnt_d;
    end
  end

  // Outputs: state decodes and direct register taps only.
  assign flush_valid_o       = (state_q == ST_FLUSH);
  assign flush_rob_idx_o     = pend_rob_idx_q;
  assign cur_epoch_o         = cur_epoch_q;
  assign fe_stall_o          = (state_q != ST_IDLE);
  assign fe_redirect_valid_o = (state_q == ST_REDIRECT);
  assign fe_redirect_pc_o    = pend_pc_q;
  assign mispredict_cnt_o    = cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_redirect_ctrl
// Directed scenarios plus randomized traffic for branch_redirect_ctrl. The
// reference model tracks a recovery "in flight" as a few booleans: flush due,
// recovered and awaiting frontend. It applies the accept and age rules using
// plain integer arithmetic. The counter is built 2 bits wide so that
// saturation is reachable.
// ---------------------------------------------------------------------------
module tb_branch_redirect_ctrl;

  localparam int ROB_W   = 5;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;

  logic             clk;
  logic             rst_n;
  logic             br_valid;
  logic             br_mispredict;
  logic [1:0]       br_epoch;
  logic [ROB_W-1:0] br_rob_idx;
  logic [31:0]      br_redirect_pc;
  logic [ROB_W-1:0] rob_head;
  logic             recover_done;
  logic             flush_valid;
  logic [ROB_W-1:0] flush_rob_idx;
  logic [1:0]       cur_epoch;
  logic             fe_stall;
  logic             fe_redirect_valid;
  logic             fe_redirect_ready;
  logic [31:0]      fe_redirect_pc;
  logic [CNT_W-1:0] mispredict_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit               m_pend;
  bit               m_flush;
  bit               m_rec;
  logic [1:0]       m_epoch;
  logic [1:0]       m_pend_epoch;
  logic [ROB_W-1:0] m_idx;
  logic [31:0]      m_pc;
  int               m_cnt;

  branch_redirect_ctrl #(.ROB_W(ROB_W), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .br_valid_i          (br_valid),
    .br_mispredict_i     (br_mispredict),
    .br_epoch_i          (br_epoch),
    .br_rob_idx_i        (br_rob_idx),
    .br_redirect_pc_i    (br_redirect_pc),
    .rob_head_i          (rob_head),
    .recover_done_i      (recover_done),
    .flush_valid_o       (flush_valid),
    .flush_rob_idx_o     (flush_rob_idx),
    .cur_epoch_o         (cur_epoch),
    .fe_stall_o          (fe_stall),
    .fe_redirect_valid_o (fe_redirect_valid),
    .fe_redirect_ready_i (fe_redirect_ready),
    .fe_redirect_pc_o    (fe_redirect_pc),
    .mispredict_cnt_o    (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int age(input logic [ROB_W-1:0] a, input logic [ROB_W-1:0] h);
    return (int'(a) - int'(h) + 32) % 32;
  endfunction

  task automatic model_clear();
    m_pend = 1'b0; m_flush = 1'b0; m_rec = 1'b0;
    m_epoch = 2'd0; m_pend_epoch = 2'd0; m_idx = '0; m_pc = 32'd0; m_cnt = 0;
  endtask

  task automatic clear_br();
    br_valid = 1'b0; br_mispredict = 1'b0; br_epoch = 2'd0;
    br_rob_idx = '0; br_redirect_pc = 32'd0;
  endtask

  task automatic drive_br(input logic [1:0] ep, input logic [ROB_W-1:0] idx, input logic [31:0] pc);
    br_valid = 1'b1; br_mispredict = 1'b1; br_epoch = ep;
    br_rob_idx = idx; br_redirect_pc = pc;
  endtask

  // One clock: evaluate the model on the current inputs, take the edge, settle.
  task automatic cycle();
    bit acc;
    acc = 1'b0;
    if (br_valid && br_mispredict) begin
      if (!m_pend) acc = (br_epoch == m_epoch);
      else acc = (br_epoch == m_pend_epoch) && (age(br_rob_idx, rob_head) < age(m_idx, rob_head));
    end
    @(posedge clk);
    if (acc) begin
      if (!m_pend) begin
        m_pend_epoch = br_epoch;
        m_epoch      = m_epoch + 2'd1;
      end
      m_pend = 1'b1; m_flush = 1'b1; m_rec = 1'b0;
      m_idx = br_rob_idx; m_pc = br_redirect_pc;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else if (m_pend) begin
      if (m_flush) m_flush = 1'b0;
      else if (!m_rec) begin
        if (recover_done) m_rec = 1'b1;
      end else if (fe_redirect_ready) begin
        m_pend = 1'b0; m_rec = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_br();
    rob_head = '0; recover_done = 1'b0; fe_redirect_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Full uninterrupted recovery with immediate recover_done and ready.
  task automatic run_seq(input logic [1:0] ep, input logic [ROB_W-1:0] idx, input logic [31:0] pc);
    drive_br(ep, idx, pc); cycle();
    clear_br(); recover_done = 1'b1; cycle(); cycle();
    recover_done = 1'b0; fe_redirect_ready = 1'b1; cycle();
    fe_redirect_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({flush_valid, fe_stall, fe_redirect_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b exp=000", {flush_valid, fe_stall, fe_redirect_valid});
    end
    checks++;
    if (cur_epoch !== 2'd0 || mispredict_cnt !== 2'd0) begin
      errors++; $display("FAIL reset_epoch_cnt got=%0d/%0d exp=0/0", cur_epoch, mispredict_cnt);
    end
  endtask

  task automatic test_basic();
    drive_br(2'd0, 5'd3, 32'h100); cycle();
    checks++;
    if (flush_valid !== 1'b1 || flush_rob_idx !== 5'd3 || cur_epoch !== 2'd1 || fe_stall !== 1'b1) begin
      errors++; $display("FAIL basic_flush got v=%b idx=%0d ep=%0d st=%b exp v=1 idx=3 ep=1 st=1",
                         flush_valid, flush_rob_idx, cur_epoch, fe_stall);
    end
    clear_br(); recover_done = 1'b1; cycle();
    checks++;
    if (flush_valid !== 1'b0 || fe_redirect_valid !== 1'b0) begin
      errors++; $display("FAIL basic_recover got flush=%b redir=%b exp 0/0", flush_valid, fe_redirect_valid);
    end
    cycle();
    checks++;
    if (fe_redirect_valid !== 1'b1 || fe_redirect_pc !== 32'h100) begin
      errors++; $display("FAIL basic_redirect got v=%b pc=%h exp v=1 pc=00000100", fe_redirect_valid, fe_redirect_pc);
    end
    recover_done = 1'b0; fe_redirect_ready = 1'b1; cycle(); fe_redirect_ready = 1'b0;
    checks++;
    if (fe_stall !== 1'b0 || fe_redirect_valid !== 1'b0 || mispredict_cnt !== 2'd1) begin
      errors++; $display("FAIL basic_done got st=%b v=%b cnt=%0d exp 0/0/1", fe_stall, fe_redirect_valid, mispredict_cnt);
    end
  endtask

  task automatic test_ignore();
    drive_br(2'd2, 5'd4, 32'h40); cycle();
    checks++;
    if (fe_stall !== 1'b0 || flush_valid !== 1'b0 || cur_epoch !== 2'd1 || mispredict_cnt !== 2'd1) begin
      errors++; $display("FAIL ignore_stale got st=%b fl=%b ep=%0d cnt=%0d exp 0/0/1/1",
                         fe_stall, flush_valid, cur_epoch, mispredict_cnt);
    end
    drive_br(2'd1, 5'd4, 32'h40); br_mispredict = 1'b0; cycle();
    checks++;
    if (fe_stall !== 1'b0 || flush_valid !== 1'b0 || mispredict_cnt !== 2'd1) begin
      errors++; $display("FAIL ignore_nomisp got st=%b fl=%b cnt=%0d exp 0/0/1", fe_stall, flush_valid, mispredict_cnt);
    end
    clear_br();
  endtask

  task automatic test_preempt_older();
    rob_head = 5'd30;
    drive_br(2'd1, 5'd2, 32'h111); cycle();
    clear_br(); cycle();
    // Older branch and recover_done in the same cycle: preempt wins.
    drive_br(2'd1, 5'd31, 32'h222); recover_done = 1'b1; cycle();
    checks++;
    if (flush_valid !== 1'b1 || flush_rob_idx !== 5'd31 || cur_epoch !== 2'd2 || mispredict_cnt !== 2'd3) begin
      errors++; $display("FAIL preempt_older got fl=%b idx=%0d ep=%0d cnt=%0d exp 1/31/2/3",
                         flush_valid, flush_rob_idx, cur_epoch, mispredict_cnt);
    end
    clear_br(); recover_done = 1'b0; cycle();
    drive_br(2'd1, 5'd5, 32'h333); cycle();
    checks++;
    if (flush_valid !== 1'b0 || flush_rob_idx !== 5'd31 || fe_stall !== 1'b1) begin
      errors++; $display("FAIL preempt_younger got fl=%b idx=%0d st=%b exp 0/31/1", flush_valid, flush_rob_idx, fe_stall);
    end
    drive_br(2'd1, 5'd31, 32'h444); cycle();
    checks++;
    if (flush_valid !== 1'b0) begin
      errors++; $display("FAIL preempt_equal got fl=%b exp 0", flush_valid);
    end
    drive_br(2'd2, 5'd30, 32'h555); cycle();
    checks++;
    if (flush_valid !== 1'b0 || flush_rob_idx !== 5'd31) begin
      errors++; $display("FAIL preempt_epoch got fl=%b idx=%0d exp 0/31", flush_valid, flush_rob_idx);
    end
    clear_br(); recover_done = 1'b1; cycle();
    checks++;
    if (fe_redirect_valid !== 1'b1 || fe_redirect_pc !== 32'h222) begin
      errors++; $display("FAIL preempt_older_pc got v=%b pc=%h exp 1/00000222", fe_redirect_valid, fe_redirect_pc);
    end
    recover_done = 1'b0; fe_redirect_ready = 1'b1; cycle(); fe_redirect_ready = 1'b0;
    checks++;
    if (fe_stall !== 1'b0) begin
      errors++; $display("FAIL preempt_older_done got st=%b exp 0", fe_stall);
    end
  endtask

  task automatic test_preempt_redirect();
    rob_head = 5'd0;
    drive_br(2'd2, 5'd10, 32'h200); cycle();
    clear_br(); recover_done = 1'b1; cycle(); cycle();
    recover_done = 1'b0;
    checks++;
    if (fe_redirect_valid !== 1'b1 || fe_redirect_pc !== 32'h200 || cur_epoch !== 2'd3) begin
      errors++; $display("FAIL redir_first got v=%b pc=%h ep=%0d exp 1/00000200/3", fe_redirect_valid, fe_redirect_pc, cur_epoch);
    end
    drive_br(2'd2, 5'd4, 32'h300); fe_redirect_ready = 1'b1; cycle();
    checks++;
    if (flush_valid !== 1'b1 || fe_stall !== 1'b1 || fe_redirect_valid !== 1'b0 ||
        flush_rob_idx !== 5'd4 || cur_epoch !== 2'd3) begin
      errors++; $display("FAIL redir_preempt got fl=%b st=%b v=%b idx=%0d ep=%0d exp 1/1/0/4/3",
                         flush_valid, fe_stall, fe_redirect_valid, flush_rob_idx, cur_epoch);
    end
    clear_br(); recover_done = 1'b1; cycle(); cycle();
    checks++;
    if (fe_redirect_valid !== 1'b1 || fe_redirect_pc !== 32'h300) begin
      errors++; $display("FAIL redir_newpc got v=%b pc=%h exp 1/00000300", fe_redirect_valid, fe_redirect_pc);
    end
    recover_done = 1'b0; cycle(); fe_redirect_ready = 1'b0;
    checks++;
    if (fe_stall !== 1'b0) begin
      errors++; $display("FAIL redir_done got st=%b exp 0", fe_stall);
    end
  endtask

  task automatic test_epoch_wrap();
    logic [1:0] exp_ep;
    logic [1:0] ep;
    int exp_cnt;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      ep = 2'(k - 1);
      run_seq(ep, 5'(k), 32'(k * 16));
      exp_ep  = 2'(k);
      exp_cnt = (k < CNT_MAX) ? k : CNT_MAX;
      checks++;
      if (cur_epoch !== exp_ep || int'(mispredict_cnt) != exp_cnt || fe_stall !== 1'b0) begin
        errors++; $display("FAIL epoch_wrap k=%0d got ep=%0d cnt=%0d st=%b exp ep=%0d cnt=%0d st=0",
                           k, cur_epoch, mispredict_cnt, fe_stall, exp_ep, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_br(2'd0, 5'd7, 32'h77); cycle();
    clear_br(); cycle();
    checks++;
    if (fe_stall !== 1'b1 || cur_epoch !== 2'd1) begin
      errors++; $display("FAIL rstmid_pre got st=%b ep=%0d exp 1/1", fe_stall, cur_epoch);
    end
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if ({flush_valid, fe_stall, fe_redirect_valid} !== 3'b000 || cur_epoch !== 2'd0 || mispredict_cnt !== 2'd0) begin
      errors++; $display("FAIL rstmid_clear got flags=%b ep=%0d cnt=%0d exp 000/0/0",
                         {flush_valid, fe_stall, fe_redirect_valid}, cur_epoch, mispredict_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_br(2'd0, 5'd9, 32'h99); cycle();
    clear_br();
    checks++;
    if (flush_valid !== 1'b1 || flush_rob_idx !== 5'd9 || cur_epoch !== 2'd1 || mispredict_cnt !== 2'd1) begin
      errors++; $display("FAIL rstmid_after got fl=%b idx=%0d ep=%0d cnt=%0d exp 1/9/1/1",
                         flush_valid, flush_rob_idx, cur_epoch, mispredict_cnt);
    end
  endtask

  task automatic test_random();
    int pick;
    for (int c = 0; c < 3000; c++) begin
      br_valid       = ($urandom_range(0, 9) < 4);
      br_mispredict  = ($urandom_range(0, 9) < 7);
      pick           = $urandom_range(0, 9);
      br_epoch       = (pick < 7) ? (m_pend ? m_pend_epoch : m_epoch) : 2'($urandom_range(0, 3));
      br_rob_idx     = 5'($urandom_range(0, 31));
      br_redirect_pc = $urandom;
      rob_head       = 5'($urandom_range(0, 31));
      recover_done   = ($urandom_range(0, 9) < 3);
      fe_redirect_ready = ($urandom_range(0, 9) < 5);
      cycle();
      checks++;
      if (flush_valid !== m_flush || fe_stall !== m_pend || fe_redirect_valid !== (m_pend && m_rec)) begin
        errors++; $display("FAIL rand_flags cyc=%0d got fl/st/rv=%b%b%b exp %b%b%b", c,
                           flush_valid, fe_stall, fe_redirect_valid, m_flush, m_pend, m_pend && m_rec);
      end
      checks++;
      if (flush_rob_idx !== m_idx || fe_redirect_pc !== m_pc) begin
        errors++; $display("FAIL rand_data cyc=%0d got idx=%0d pc=%h exp idx=%0d pc=%h", c,
                           flush_rob_idx, fe_redirect_pc, m_idx, m_pc);
      end
      checks++;
      if (cur_epoch !== m_epoch || int'(mispredict_cnt) != m_cnt) begin
        errors++; $display("FAIL rand_epoch_cnt cyc=%0d got ep=%0d cnt=%0d exp ep=%0d cnt=%0d", c,
                           cur_epoch, mispredict_cnt, m_epoch, m_cnt);
      end
    end
    clear_br(); recover_done = 1'b0; fe_redirect_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_br();
    rob_head = '0; recover_done = 1'b0; fe_redirect_ready = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_ignore();
    test_preempt_older();
    test_preempt_redirect();
    test_epoch_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
